// File: rtl/exec_ctrl.sv
// Execute-stage controller: latches a staged instruction, decodes it and sequences the
// accumulator, ALU and data RAM strobes, handshaking completion back to the fetch stage.
module exec_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       instr_valid,
   input  logic [4:0] StageRegInstr_out,
   input  logic [2:0] StageRegAddrMode_out,
   output logic       ACCld_str,
   output logic       ACCinMUXselect,
   output logic       shiftercontrol,
   output logic       ALUinMUXselect,
   output logic       ALUcontrol_in,
   output logic       DataRAMenable,
   output logic       DataRAMread_en,
   output logic       DRAMaddrMUXselect,
   output logic       IndirectAddrRegld_str,
   output logic       exec_busy,
   output logic       exec_done,
   output logic       halted,
   output logic       illegal
);

   localparam logic [4:0] OpNop = 5'b00000;
   localparam logic [4:0] OpLda = 5'b00001;
   localparam logic [4:0] OpSta = 5'b00010;
   localparam logic [4:0] OpAdd = 5'b00011;
   localparam logic [4:0] OpSub = 5'b00100;
   localparam logic [4:0] OpShl = 5'b00101;
   localparam logic [4:0] OpIn  = 5'b00110;
   localparam logic [4:0] OpHlt = 5'b11111;

   localparam logic [2:0] ModeImm = 3'b000;
   localparam logic [2:0] ModeDir = 3'b001;
   localparam logic [2:0] ModeInd = 3'b010;

   typedef enum logic [2:0] {
      StIdle, StDecode, StIndRd, StMemRd, StExec, StMemWr, StDone, StHalt
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] opcode_q;
   logic [2:0] mode_q;
   logic       illegal_q;

   logic       accept;
   logic       is_mem_op;
   logic       is_sta;
   logic       legal_op;
   logic       bad_instr;

   assign accept = (state_q == StIdle) && instr_valid;

   always_comb begin
      is_mem_op = (opcode_q == OpLda) || (opcode_q == OpAdd) || (opcode_q == OpSub);
      is_sta    = (opcode_q == OpSta);
      legal_op  = is_mem_op || is_sta || (opcode_q == OpNop) || (opcode_q == OpShl) ||
                  (opcode_q == OpIn) || (opcode_q == OpHlt);
      // STA has no immediate form; NOP/SHL/IN/HLT ignore the mode field entirely
      bad_instr = !legal_op ||
                  (is_mem_op && (mode_q != ModeImm) && (mode_q != ModeDir) &&
                   (mode_q != ModeInd)) ||
                  (is_sta && (mode_q != ModeDir) && (mode_q != ModeInd));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         opcode_q  <= 5'b00000;
         mode_q    <= 3'b000;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            opcode_q <= StageRegInstr_out;
            mode_q   <= StageRegAddrMode_out;
         end
         if ((state_q == StDecode) && bad_instr) begin
            illegal_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (instr_valid) state_d = StDecode;
         end
         StDecode: begin
            if (bad_instr || (opcode_q == OpNop))             state_d = StDone;
            else if (opcode_q == OpHlt)                       state_d = StHalt;
            else if ((opcode_q == OpShl) || (opcode_q == OpIn)) state_d = StExec;
            else if (mode_q == ModeInd)                       state_d = StIndRd;
            else if (is_sta)                                  state_d = StMemWr;
            else if (mode_q == ModeImm)                       state_d = StExec;
            else                                              state_d = StMemRd;
         end
         StIndRd: state_d = is_sta ? StMemWr : StMemRd;
         StMemRd: state_d = StExec;
         StExec:  state_d = StDone;
         StMemWr: state_d = StDone;
         StDone:  state_d = StIdle;
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ACCld_str             = 1'b0;
      ACCinMUXselect        = 1'b0;
      shiftercontrol        = 1'b0;
      ALUinMUXselect        = 1'b0;
      ALUcontrol_in         = 1'b0;
      DataRAMenable         = 1'b0;
      DataRAMread_en        = 1'b0;
      DRAMaddrMUXselect     = 1'b0;
      IndirectAddrRegld_str = 1'b0;
      exec_done             = 1'b0;
      exec_busy             = (state_q != StIdle) && (state_q != StHalt);
      halted                = (state_q == StHalt);
      illegal               = illegal_q;
      unique case (state_q)
         StIndRd: begin
            DataRAMenable         = 1'b1;
            DataRAMread_en        = 1'b1;
            IndirectAddrRegld_str = 1'b1;
         end
         StMemRd: begin
            DataRAMenable     = 1'b1;
            DataRAMread_en    = 1'b1;
            DRAMaddrMUXselect = (mode_q == ModeInd);
         end
         StMemWr: begin
            DataRAMenable     = 1'b1;
            DRAMaddrMUXselect = (mode_q == ModeInd);
         end
         StExec: begin
            ACCld_str      = 1'b1;
            ALUcontrol_in  = (opcode_q == OpSub);
            ALUinMUXselect = is_mem_op && (mode_q == ModeImm);
            shiftercontrol = (opcode_q == OpShl);
            ACCinMUXselect = (opcode_q == OpIn);
         end
         StDone: exec_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios plus random instructions, each checked cycle by
// cycle against an expected stage sequence derived from the instruction's class.
module tb_exec_ctrl;

   localparam logic [4:0] OpNop = 5'b00000;
   localparam logic [4:0] OpLda = 5'b00001;
   localparam logic [4:0] OpSta = 5'b00010;
   localparam logic [4:0] OpAdd = 5'b00011;
   localparam logic [4:0] OpSub = 5'b00100;
   localparam logic [4:0] OpShl = 5'b00101;
   localparam logic [4:0] OpIn  = 5'b00110;
   localparam logic [4:0] OpHlt = 5'b11111;

   typedef struct packed {
      logic acc_ld;
      logic acc_in_sel;
      logic shift;
      logic alu_in_sel;
      logic alu_ctl;
      logic ram_en;
      logic ram_rd;
      logic addr_sel;
      logic ind_ld;
      logic busy;
      logic done;
      logic halt;
   } outs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid;
   logic [4:0] StageRegInstr_out;
   logic [2:0] StageRegAddrMode_out;
   logic       ACCld_str, ACCinMUXselect, shiftercontrol, ALUinMUXselect, ALUcontrol_in;
   logic       DataRAMenable, DataRAMread_en, DRAMaddrMUXselect, IndirectAddrRegld_str;
   logic       exec_busy, exec_done, halted, illegal;

   outs_t      obs;
   int         checks = 0;
   int         errors = 0;
   logic       model_ill = 1'b0;

   always #5 clk = ~clk;

   exec_ctrl dut (
      .clk                   (clk),
      .reset                 (reset),
      .instr_valid           (instr_valid),
      .StageRegInstr_out     (StageRegInstr_out),
      .StageRegAddrMode_out  (StageRegAddrMode_out),
      .ACCld_str             (ACCld_str),
      .ACCinMUXselect        (ACCinMUXselect),
      .shiftercontrol        (shiftercontrol),
      .ALUinMUXselect        (ALUinMUXselect),
      .ALUcontrol_in         (ALUcontrol_in),
      .DataRAMenable         (DataRAMenable),
      .DataRAMread_en        (DataRAMread_en),
      .DRAMaddrMUXselect     (DRAMaddrMUXselect),
      .IndirectAddrRegld_str (IndirectAddrRegld_str),
      .exec_busy             (exec_busy),
      .exec_done             (exec_done),
      .halted                (halted),
      .illegal               (illegal)
   );

   assign obs = {ACCld_str, ACCinMUXselect, shiftercontrol, ALUinMUXselect, ALUcontrol_in,
                 DataRAMenable, DataRAMread_en, DRAMaddrMUXselect, IndirectAddrRegld_str,
                 exec_busy, exec_done, halted};

   task automatic check(input string tag, input outs_t exp);
      checks++;
      assert ({obs, illegal} === {exp, model_ill}) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, {obs, illegal}, {exp, model_ill});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit mem_op(input logic [4:0] op);
      return (op == OpLda) || (op == OpAdd) || (op == OpSub);
   endfunction

   function automatic bit is_bad(input logic [4:0] op, input logic [2:0] mode);
      bit legal;
      legal = (op <= OpIn) || (op == OpHlt);
      if (!legal) return 1'b1;
      if (mem_op(op) && (mode > 3'd2)) return 1'b1;
      if ((op == OpSta) && !((mode == 3'd1) || (mode == 3'd2))) return 1'b1;
      return 1'b0;
   endfunction

   // Expected per-cycle outputs, cycle 1 (DECODE) first; ends with IDLE except for HLT.
   task automatic build_plan(input logic [4:0] op, input logic [2:0] mode, output outs_t plan[$]);
      outs_t o;
      bit    bad;
      bad = is_bad(op, mode);
      plan = {};
      o = '0; o.busy = 1'b1;
      plan.push_back(o);
      if (!bad && (op == OpHlt)) begin
         o = '0; o.halt = 1'b1;
         repeat (4) plan.push_back(o);
         return;
      end
      if (!bad && (op != OpNop)) begin
         if ((mode == 3'd2) && (mem_op(op) || (op == OpSta))) begin
            o = '0; o.busy = 1'b1; o.ram_en = 1'b1; o.ram_rd = 1'b1; o.ind_ld = 1'b1;
            plan.push_back(o);
         end
         if (op == OpSta) begin
            o = '0; o.busy = 1'b1; o.ram_en = 1'b1; o.addr_sel = (mode == 3'd2);
            plan.push_back(o);
         end else begin
            if (mem_op(op) && (mode != 3'd0)) begin
               o = '0; o.busy = 1'b1; o.ram_en = 1'b1; o.ram_rd = 1'b1;
               o.addr_sel = (mode == 3'd2);
               plan.push_back(o);
            end
            o = '0; o.busy = 1'b1; o.acc_ld = 1'b1;
            o.alu_ctl    = (op == OpSub);
            o.alu_in_sel = mem_op(op) && (mode == 3'd0);
            o.shift      = (op == OpShl);
            o.acc_in_sel = (op == OpIn);
            plan.push_back(o);
         end
      end
      o = '0; o.busy = 1'b1; o.done = 1'b1;
      plan.push_back(o);
      plan.push_back('0);
   endtask

   // noise: scribble the stage register and pulse instr_valid while the instruction runs
   task automatic run_instr(input logic [4:0] op, input logic [2:0] mode, input bit noise);
      outs_t plan[$];
      build_plan(op, mode, plan);
      instr_valid          = 1'b1;
      StageRegInstr_out    = op;
      StageRegAddrMode_out = mode;
      tick();
      for (int i = 0; i < plan.size(); i++) begin
         check($sformatf("op%0d_m%0d_c%0d", op, mode, i + 1), plan[i]);
         if ((i == 0) && is_bad(op, mode)) model_ill = 1'b1;
         if (i == plan.size() - 1) begin
            instr_valid = 1'b0;
            break;
         end
         instr_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
         if (noise) begin
            StageRegInstr_out    = 5'($urandom);
            StageRegAddrMode_out = 3'($urandom);
         end
         tick();
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      instr_valid = 1'b0;
      tick();
      model_ill = 1'b0;
      check("rst_hold", '0);
      tick();
      reset = 1'b0;
      tick();
      check("rst_rel", '0);
   endtask

   initial begin
      outs_t       o;
      logic [4:0]  op;
      logic [2:0]  mode;
      logic [4:0]  ops [8];
      ops = '{OpNop, OpLda, OpSta, OpAdd, OpSub, OpShl, OpIn, OpHlt};
      reset                = 1'b1;
      instr_valid          = 1'b0;
      StageRegInstr_out    = '0;
      StageRegAddrMode_out = '0;

      do_reset();
      run_instr(OpAdd, 3'b000, 1'b0);
      run_instr(OpLda, 3'b001, 1'b0);
      run_instr(OpSub, 3'b010, 1'b0);
      run_instr(OpSta, 3'b010, 1'b0);
      run_instr(OpSta, 3'b001, 1'b0);
      run_instr(OpSta, 3'b000, 1'b0);
      do_reset();
      run_instr(5'b01010, 3'b000, 1'b0);
      run_instr(OpNop, 3'b111, 1'b0);
      do_reset();
      run_instr(OpLda, 3'b011, 1'b0);
      do_reset();
      run_instr(OpAdd, 3'b000, 1'b1);
      run_instr(OpLda, 3'b010, 1'b1);
      run_instr(OpHlt, 3'b000, 1'b1);
      do_reset();

      // Reset landing in MEM_RD of an indirect LDA
      instr_valid          = 1'b1;
      StageRegInstr_out    = OpLda;
      StageRegAddrMode_out = 3'b010;
      tick();
      instr_valid = 1'b0;
      tick();
      o = '0; o.busy = 1'b1; o.ram_en = 1'b1; o.ram_rd = 1'b1; o.ind_ld = 1'b1;
      check("mid_ind_rd", o);
      tick();
      o = '0; o.busy = 1'b1; o.ram_en = 1'b1; o.ram_rd = 1'b1; o.addr_sel = 1'b1;
      check("mid_mem_rd", o);
      reset = 1'b1;
      tick();
      model_ill = 1'b0;
      check("mid_rst", '0);
      reset = 1'b0;
      run_instr(OpIn, 3'($urandom), 1'b0);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(3, 0) != 0) op = ops[$urandom_range(7, 0)];
         else                           op = 5'($urandom);
         if ($urandom_range(3, 0) != 0) mode = 3'($urandom_range(2, 0));
         else                           mode = 3'($urandom);
         run_instr(op, mode, 1'($urandom_range(1, 0)));
         if ((op == OpHlt) || ($urandom_range(7, 0) == 0)) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
